// File: rtl/gb_audio_mixer_n.sv
// gb_audio_mixer_n: N-channel stereo mixer with per-channel gain/mute, one multiply-accumulate per cycle,
// saturation and clip/overrun flags. Define GB_MIXER_STEREO_MIX_EN to add the stereo cross-mix stage.
module gb_audio_mixer_n #(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 16,
    parameter int GAIN_W     = 4,
    parameter int NORM_SHIFT = 1
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       sample_ce,
    input  logic                       signed_in,
    input  logic [CHANNELS*WIDTH-1:0]  ch_l,
    input  logic [CHANNELS*WIDTH-1:0]  ch_r,
    input  logic [CHANNELS*GAIN_W-1:0] ch_gain,
    input  logic [CHANNELS-1:0]        ch_mute,
    input  logic [1:0]                 mix_mode,
    output logic [WIDTH-1:0]           audio_l,
    output logic [WIDTH-1:0]           audio_r,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       clip,
    output logic                       overrun
);

    localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PROD_W = WIDTH + GAIN_W + 1;
    localparam int ACC_W  = WIDTH + GAIN_W + $clog2(CHANNELS) + 1;
    localparam int SHIFT  = GAIN_W - 1 + NORM_SHIFT;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_MIX  = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t                     state, state_nx;
    logic [IDX_W-1:0]           idx;
    logic                       accept;

    logic [CHANNELS*WIDTH-1:0]  snap_l, snap_r;
    logic [CHANNELS*GAIN_W-1:0] snap_gain;
    logic [CHANNELS-1:0]        snap_mute;
    logic                       snap_signed;

    logic signed [WIDTH-1:0]    smp_l, smp_r;
    logic signed [GAIN_W:0]     gain_s;
    logic signed [PROD_W-1:0]   prod_l, prod_r;
    logic signed [ACC_W-1:0]    acc_l, acc_r;
    logic signed [WIDTH-1:0]    sat_l, sat_r;
    logic                       clip_l, clip_r;
    logic [WIDTH-1:0]           fin_l, fin_r;
    logic                       fin_clip;

    // A strobe landing on the out_valid cycle is treated as arriving while busy.
    assign accept = sample_ce && (state == S_IDLE) && !out_valid;

    // NOTE: registered state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        // NOTE: next state gets a default first so no path leaves it unassigned (no latch).
        state_nx = state;
        unique case (state)
            S_IDLE: if (accept) state_nx = S_ACC;
`ifdef GB_MIXER_STEREO_MIX_EN
            S_ACC:  if (idx == LAST_IDX) state_nx = S_MIX;
`else
            S_ACC:  if (idx == LAST_IDX) state_nx = S_OUT;
`endif
            S_MIX:  state_nx = S_OUT;
            S_OUT:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset)                idx <= '0;
        else if (accept)          idx <= '0;
        else if (state == S_ACC)  idx <= idx + IDX_W'(1);
    end

    // Offset-binary samples are moved to two's complement by flipping the MSB.
    always_comb begin
        smp_l  = snap_l[int'(idx)*WIDTH +: WIDTH] ^ {~snap_signed, {(WIDTH-1){1'b0}}};
        smp_r  = snap_r[int'(idx)*WIDTH +: WIDTH] ^ {~snap_signed, {(WIDTH-1){1'b0}}};
        gain_s = snap_mute[idx] ? '0 : {1'b0, snap_gain[int'(idx)*GAIN_W +: GAIN_W]};
        prod_l = PROD_W'(smp_l) * PROD_W'(gain_s);
        prod_r = PROD_W'(smp_r) * PROD_W'(gain_s);
    end

    function automatic logic [WIDTH:0] saturate(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) return {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
        if (v < SAT_MIN) return {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
        return {1'b0, WIDTH'(v)};
    endfunction

    always_comb begin
        {clip_l, sat_l} = saturate(acc_l >>> SHIFT);
        {clip_r, sat_r} = saturate(acc_r >>> SHIFT);
    end

`ifdef GB_MIXER_STEREO_MIX_EN
    localparam int EXT_W = WIDTH + 3;

    logic [1:0]              snap_mode;
    logic signed [WIDTH-1:0] hold_l, hold_r;
    logic                    hold_clip;

    // Weighted cross-mix of two in-range values stays in range, so no re-saturation.
    function automatic logic [WIDTH-1:0] cross(input logic signed [WIDTH-1:0] a,
                                                input logic signed [WIDTH-1:0] b,
                                                input logic [1:0] mode);
        logic signed [EXT_W-1:0] ea, eb;
        ea = EXT_W'(a);
        eb = EXT_W'(b);
        case (mode)
            2'd1:    return WIDTH'(((ea <<< 3) - ea + eb) >>> 3);
            2'd2:    return WIDTH'(((ea <<< 1) + ea + eb) >>> 2);
            2'd3:    return WIDTH'((ea + eb) >>> 1);
            default: return a;
        endcase
    endfunction

    always_comb begin
        fin_l    = cross(hold_l, hold_r, snap_mode);
        fin_r    = cross(hold_r, hold_l, snap_mode);
        fin_clip = hold_clip;
    end
`else
    logic unused_mix_mode;
    assign unused_mix_mode = ^mix_mode;

    always_comb begin
        fin_l    = sat_l;
        fin_r    = sat_r;
        fin_clip = clip_l | clip_r;
    end
`endif

    // NOTE: snapshot and accumulator registers carry no reset; they are always loaded before use.
    always_ff @(posedge clk_sys) begin
        if (accept) begin
            snap_l      <= ch_l;
            snap_r      <= ch_r;
            snap_gain   <= ch_gain;
            snap_mute   <= ch_mute;
            snap_signed <= signed_in;
`ifdef GB_MIXER_STEREO_MIX_EN
            snap_mode   <= mix_mode;
`endif
            acc_l       <= '0;
            acc_r       <= '0;
        end else if (state == S_ACC) begin
            acc_l <= acc_l + ACC_W'(prod_l);
            acc_r <= acc_r + ACC_W'(prod_r);
        end
`ifdef GB_MIXER_STEREO_MIX_EN
        if (state == S_MIX) begin
            hold_l    <= sat_l;
            hold_r    <= sat_r;
            hold_clip <= clip_l | clip_r;
        end
`endif
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            audio_l   <= '0;
            audio_r   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            clip      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= (state == S_OUT);
            clip      <= (state == S_OUT) && fin_clip;
            if (state == S_OUT) begin
                audio_l <= {fin_l[WIDTH-1] ^ ~snap_signed, fin_l[WIDTH-2:0]};
                audio_r <= {fin_r[WIDTH-1] ^ ~snap_signed, fin_r[WIDTH-2:0]};
            end
            if (accept)               busy <= 1'b1;
            else if (state == S_OUT)  busy <= 1'b0;
            if (sample_ce && !accept) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gb_audio_mixer_n.sv
// Directed self-checking bench for gb_audio_mixer_n (CHANNELS=2, WIDTH=16, GAIN_W=4, NORM_SHIFT=1).
module tb_gb_audio_mixer_n;

`ifdef GB_MIXER_STEREO_MIX_EN
    localparam int LAT = 5;
    localparam logic [15:0] EXP_ML [4] = '{16'h2000, 16'h1C00, 16'h1800, 16'h1000};
    localparam logic [15:0] EXP_MR [4] = '{16'h0000, 16'h0400, 16'h0800, 16'h1000};
`else
    localparam int LAT = 4;
    localparam logic [15:0] EXP_ML [4] = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
    localparam logic [15:0] EXP_MR [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        sample_ce;
    logic        signed_in;
    logic [31:0] ch_l, ch_r;
    logic [7:0]  ch_gain;
    logic [1:0]  ch_mute;
    logic [1:0]  mix_mode;
    logic [15:0] audio_l, audio_r;
    logic        out_valid, busy, clip, overrun;

    int checks = 0;
    int errors = 0;

    logic [15:0] got_l, got_r;
    logic        got_clip;
    int          pulses;

    gb_audio_mixer_n #(
        .CHANNELS(2), .WIDTH(16), .GAIN_W(4), .NORM_SHIFT(1)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .sample_ce (sample_ce),
        .signed_in (signed_in),
        .ch_l      (ch_l),
        .ch_r      (ch_r),
        .ch_gain   (ch_gain),
        .ch_mute   (ch_mute),
        .mix_mode  (mix_mode),
        .audio_l   (audio_l),
        .audio_r   (audio_r),
        .out_valid (out_valid),
        .busy      (busy),
        .clip      (clip),
        .overrun   (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Strobe one mix, wait for out_valid (bounded), capture outputs, then leave the out_valid cycle.
    task automatic run_mix(input string tag, output logic [15:0] l, output logic [15:0] r,
                           output logic c);
        int n;
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, out_valid ? 32'(n) : 32'hFFFF_FFFF, 32'(LAT));
        l = audio_l;
        r = audio_r;
        c = clip;
        tick();
    endtask

    task automatic count_pulses(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            if (out_valid) cnt++;
            tick();
        end
    endtask

    initial begin
        reset     = 1'b1;
        sample_ce = 1'b0;
        signed_in = 1'b1;
        ch_l      = '0;
        ch_r      = '0;
        ch_gain   = 8'h88;
        ch_mute   = 2'b00;
        mix_mode  = 2'd0;
        repeat (3) tick();

        // Reset state
        check("rst_audio_l", 32'(audio_l), 32'h0);
        check("rst_audio_r", 32'(audio_r), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_clip", 32'(clip), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        reset = 1'b0;
        tick();

        // Basic mix with cycle-exact busy/out_valid; inputs change after the snapshot
        ch_l = 32'h1000_2000;
        ch_r = 32'h0300_0100;
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        ch_l = 32'h7FFF_7FFF;
        for (int c = 1; c < LAT; c++) begin
            check($sformatf("mix_busy_c%0d", c), 32'(busy), 32'h1);
            check($sformatf("mix_nvalid_c%0d", c), 32'(out_valid), 32'h0);
            tick();
        end
        check("mix_valid", 32'(out_valid), 32'h1);
        check("mix_busy_low", 32'(busy), 32'h0);
        check("mix_audio_l", 32'(audio_l), 32'h1800);
        check("mix_audio_r", 32'(audio_r), 32'h0200);
        check("mix_clip", 32'(clip), 32'h0);
        tick();
        check("mix_valid_pulse", 32'(out_valid), 32'h0);
        check("mix_hold_l", 32'(audio_l), 32'h1800);

        // Negative sample, unequal gains: 0x4000*4 + (-0x2000)*12 = -0x8000, >>4 = -0x800
        ch_l = 32'hE000_4000;
        ch_r = 32'h0000_0000;
        ch_gain = 8'hC4;
        run_mix("gain", got_l, got_r, got_clip);
        check("gain_audio_l", 32'(got_l), 32'hF800);
        check("gain_audio_r", 32'(got_r), 32'h0000);
        check("gain_clip", 32'(got_clip), 32'h0);

        // Positive and negative saturation
        ch_gain = 8'hFF;
        ch_l = 32'h7FFF_7FFF;
        run_mix("satp", got_l, got_r, got_clip);
        check("satp_audio_l", 32'(got_l), 32'h7FFF);
        check("satp_audio_r", 32'(got_r), 32'h0000);
        check("satp_clip", 32'(got_clip), 32'h1);
        check("satp_clip_pulse", 32'(clip), 32'h0);
        ch_l = 32'h8000_8000;
        run_mix("satn", got_l, got_r, got_clip);
        check("satn_audio_l", 32'(got_l), 32'h8000);
        check("satn_clip", 32'(got_clip), 32'h1);

        // Mute: channel 1 carries full-scale data that must not contribute
        ch_gain = 8'h88;
        ch_mute = 2'b10;
        ch_l = 32'h7FFF_4000;
        ch_r = 32'h7FFF_0000;
        run_mix("mute", got_l, got_r, got_clip);
        check("mute_audio_l", 32'(got_l), 32'h2000);
        check("mute_audio_r", 32'(got_r), 32'h0000);

        // Offset-binary: 0xC000 -> +0x4000 -> 0x2000 -> 0xA000; 0x8000 is mid-scale
        signed_in = 1'b0;
        ch_l = 32'h7FFF_C000;
        ch_r = 32'h7FFF_8000;
        run_mix("unsg", got_l, got_r, got_clip);
        check("unsg_audio_l", 32'(got_l), 32'hA000);
        check("unsg_audio_r", 32'(got_r), 32'h8000);
        signed_in = 1'b1;
        check("no_spurious_overrun", 32'(overrun), 32'h0);

        // Stereo cross-mix modes (ignored when the cross-mix stage is not built)
        ch_l = 32'h0000_4000;
        ch_r = 32'h0000_0000;
        for (int m = 0; m < 4; m++) begin
            mix_mode = 2'(m);
            run_mix($sformatf("mode%0d", m), got_l, got_r, got_clip);
            check($sformatf("mode%0d_audio_l", m), 32'(got_l), 32'(EXP_ML[m]));
            check($sformatf("mode%0d_audio_r", m), 32'(got_r), 32'(EXP_MR[m]));
        end
        mix_mode = 2'd0;
        ch_mute = 2'b00;

        // Overrun: second strobe at cycle 2 with different data is dropped
        ch_l = 32'h1000_2000;
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        tick();
        ch_l = 32'h7000_7000;
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        check("ovr_flag", 32'(overrun), 32'h1);
        count_pulses(12, pulses);
        check("ovr_single_valid", 32'(pulses), 32'h1);
        check("ovr_audio_l", 32'(audio_l), 32'h1800);
        check("ovr_busy_idle", 32'(busy), 32'h0);

        // Overrun stays set across a clean mix
        ch_l = 32'h1000_2000;
        run_mix("sticky", got_l, got_r, got_clip);
        check("sticky_audio_l", 32'(got_l), 32'h1800);
        check("sticky_overrun", 32'(overrun), 32'h1);

        // Reset during cycle 2 of a mix discards it
        ch_l = 32'h0000_4000;
        sample_ce = 1'b1;
        tick();
        sample_ce = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmid_audio_l", 32'(audio_l), 32'h0);
        check("rmid_audio_r", 32'(audio_r), 32'h0);
        check("rmid_busy", 32'(busy), 32'h0);
        check("rmid_overrun", 32'(overrun), 32'h0);
        count_pulses(10, pulses);
        check("rmid_no_valid", 32'(pulses), 32'h0);
        check("rmid_audio_l_held", 32'(audio_l), 32'h0);

        // Mixer is usable again after reset
        ch_l = 32'h1000_2000;
        ch_r = 32'h0300_0100;
        run_mix("post", got_l, got_r, got_clip);
        check("post_audio_l", 32'(got_l), 32'h1800);
        check("post_audio_r", 32'(got_r), 32'h0200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
